// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Receive-side UART deframer. Samples the serial line on an oversampling tick,
// detects the start bit and recovers DATA_BITS data bits, LSB first. It then
// checks an optional parity bit and the stop bit, and presents each received
// word with a one-clock valid strobe. The error flags hold until the next frame.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit. Without it, parity_error_o is tied to 0.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            asynchronous active-high reset
//   baud_tick_i      one-clock pulse at OVERSAMPLE x baud rate
//   rx_i             asynchronous serial line, idle high
//   rx_data_o        last received data word
//   rx_valid_o       one-clock pulse when a frame completes
//   framing_error_o  stop bit sampled low in the last frame
//   parity_error_o   parity mismatch in the last frame
//   rx_busy_o        receiver is not idle
module uart_rx_deframer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 framing_error_o,
  output logic                 parity_error_o,
  output logic                 rx_busy_o
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS);

  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e               state_q;
  logic [TickW-1:0]     tick_q;
  logic [BitW-1:0]      bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 framing_error_q;
  logic                 line_armed_q;
  logic                 rx_meta_q;
  logic                 rxs_q;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad_q;
  logic                 parity_error_q;
`endif

  // Two-flop synchronizer. It resets to the idle-high line level, so leaving
  // reset never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      tick_q          <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
      line_armed_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_bad_q    <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
      if (baud_tick_i) begin
        case (state_q)
          StIdle: begin
            if (rxs_q) begin
              line_armed_q <= 1'b1;
            end
            if (line_armed_q && !rxs_q) begin
              state_q <= StStart;
              tick_q  <= '0;
            end
          end
          StStart: begin
            // Check the line again in the middle of the start bit to reject glitches.
            if (tick_q == TickHalf) begin
              if (!rxs_q) begin
                state_q <= StData;
                tick_q  <= '0;
                bit_q   <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
          StData: begin
            if (tick_q == TickLast) begin
              tick_q  <= '0;
              // Each new bit enters at the MSB, so the first bit ends up in the LSB.
              shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
              if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
`endif
              end else begin
                bit_q <= bit_q + BitW'(1);
              end
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          StParity: begin
            if (tick_q == TickLast) begin
              tick_q       <= '0;
              parity_bad_q <= (^shift_q) ^ rxs_q ^ PARITY_ODD;
              state_q      <= StStop;
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
`endif
          StStop: begin
            if (tick_q == TickLast) begin
              tick_q          <= '0;
              rx_data_q       <= shift_q;
              framing_error_q <= ~rxs_q;
              rx_valid_q      <= 1'b1;
              state_q         <= StIdle;
`ifdef UART_RX_PARITY_EN
              parity_error_q  <= parity_bad_q;
`endif
              // A line still low at the stop bit is a break. Do not start a new
              // frame until the line has gone high again.
              if (!rxs_q) begin
                line_armed_q <= 1'b0;
              end
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign framing_error_o = framing_error_q;
  assign rx_busy_o       = (state_q != StIdle);

`ifdef UART_RX_PARITY_EN
  assign parity_error_o = parity_error_q;
`else
  // PARITY_ODD has no effect here. It is referenced only so the parameter
  // stays bound when parity is compiled out.
  assign parity_error_o = 1'b0 & PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
module tb_uart_rx_deframer;

  localparam int unsigned DataBits = 8;
  localparam int unsigned Os       = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                baud_tick;
  logic                rx;
  logic [DataBits-1:0] rx_data;
  logic                rx_valid;
  logic                framing_error;
  logic                parity_error;
  logic                rx_busy;

  int n_pass    = 0;
  int n_total   = 0;
  int valid_cnt = 0;
  int exp_valid = 0;
  int div       = 1;
  int phase     = 0;
  logic [DataBits-1:0] vq[$];

  uart_rx_deframer #(
    .DATA_BITS (DataBits),
    .OVERSAMPLE(Os),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .baud_tick_i    (baud_tick),
    .rx_i           (rx),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .framing_error_o(framing_error),
    .parity_error_o (parity_error),
    .rx_busy_o      (rx_busy)
  );

  always #5 clk = ~clk;

  // Counts valid strobes at mid-cycle. A strobe wider than one clock is counted more than once.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      vq.push_back(rx_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive the line and the baud tick 1 time unit after the rising edge.
  task automatic cyc(input logic v);
    @(posedge clk);
    #1;
    rx        = v;
    baud_tick = (phase == 0);
    phase     = (phase + 1 >= div) ? 0 : phase + 1;
  endtask

  task automatic bit_time(input logic v);
    repeat (Os * div) cyc(v);
  endtask

  task automatic send_frame(input logic [DataBits-1:0] d, input logic par, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < DataBits; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(par);
`else
    if (par === 1'bx) bit_time(1'b1);
`endif
    bit_time(stop);
  endtask

  initial begin
    rst       = 1'b1;
    rx        = 1'b1;
    baud_tick = 1'b0;
    #2;
    check("reset rx_data", 32'(rx_data), 32'h0);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset framing_error", 32'(framing_error), 32'h0);
    check("reset parity_error", 32'(parity_error), 32'h0);
    check("reset rx_busy", 32'(rx_busy), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bit_time(1'b1);
    bit_time(1'b1);

    // Clean 0xA5 frame. It has four 1 bits, so the even parity bit is 0.
    send_frame(8'hA5, 1'b0, 1'b1);
    bit_time(1'b1);
    exp_valid++;
    check("a5 valid count", 32'(valid_cnt), 32'(exp_valid));
    check("a5 rx_data", 32'(rx_data), 32'hA5);
    check("a5 framing_error", 32'(framing_error), 32'h0);
    check("a5 parity_error", 32'(parity_error), 32'h0);
    check("a5 rx_busy", 32'(rx_busy), 32'h0);

    // 0x3C with the stop bit low, then the line held low for 3 bit times (a break).
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (3) bit_time(1'b0);
    exp_valid++;
    check("break valid count", 32'(valid_cnt), 32'(exp_valid));
    check("break rx_data", 32'(rx_data), 32'h3C);
    check("break framing_error", 32'(framing_error), 32'h1);
    check("break no retrigger busy", 32'(rx_busy), 32'h0);
    bit_time(1'b1);
    bit_time(1'b1);
    check("after break valid count", 32'(valid_cnt), 32'(exp_valid));
    check("after break busy", 32'(rx_busy), 32'h0);

    // A low glitch of 4 ticks while idle starts a frame and then aborts it.
    repeat (4) cyc(1'b0);
    check("glitch busy in start", 32'(rx_busy), 32'h1);
    bit_time(1'b1);
    bit_time(1'b1);
    check("glitch busy after", 32'(rx_busy), 32'h0);
    check("glitch valid count", 32'(valid_cnt), 32'(exp_valid));
    check("glitch rx_data held", 32'(rx_data), 32'h3C);
    check("glitch framing held", 32'(framing_error), 32'h1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three 1 bits, so even parity expects a parity bit of 1.
    send_frame(8'h07, 1'b0, 1'b1);
    bit_time(1'b1);
    exp_valid++;
    check("par bad valid count", 32'(valid_cnt), 32'(exp_valid));
    check("par bad rx_data", 32'(rx_data), 32'h07);
    check("par bad parity_error", 32'(parity_error), 32'h1);
    check("par bad framing_error", 32'(framing_error), 32'h0);
    send_frame(8'h07, 1'b1, 1'b1);
    bit_time(1'b1);
    exp_valid++;
    check("par ok valid count", 32'(valid_cnt), 32'(exp_valid));
    check("par ok rx_data", 32'(rx_data), 32'h07);
    check("par ok parity_error", 32'(parity_error), 32'h0);
`endif

    // Reset asserted during data bit 4 of a 0x55 frame.
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    repeat (8) cyc(1'b1);
    check("mid-frame busy before rst", 32'(rx_busy), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid rst rx_data", 32'(rx_data), 32'h0);
    check("mid rst rx_valid", 32'(rx_valid), 32'h0);
    check("mid rst framing_error", 32'(framing_error), 32'h0);
    check("mid rst parity_error", 32'(parity_error), 32'h0);
    check("mid rst rx_busy", 32'(rx_busy), 32'h0);
    repeat (2) cyc(1'b1);
    #1 rst = 1'b0;
    bit_time(1'b1);
    bit_time(1'b1);
    check("mid rst no valid", 32'(valid_cnt), 32'(exp_valid));
    send_frame(8'h55, 1'b0, 1'b1);
    bit_time(1'b1);
    exp_valid++;
    check("55 valid count", 32'(valid_cnt), 32'(exp_valid));
    check("55 rx_data", 32'(rx_data), 32'h55);
    check("55 framing_error", 32'(framing_error), 32'h0);
    check("55 parity_error", 32'(parity_error), 32'h0);

    // Back-to-back frames with a baud tick every 3 clocks.
    div   = 3;
    phase = 0;
    vq.delete();
    bit_time(1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b1, 1'b1);
    bit_time(1'b1);
    exp_valid += 2;
    check("b2b valid count", 32'(valid_cnt), 32'(exp_valid));
    check("b2b queue size", 32'(vq.size()), 32'd2);
    if (vq.size() == 2) begin
      check("b2b first word", 32'(vq[0]), 32'h01);
      check("b2b second word", 32'(vq[1]), 32'hFE);
    end
    check("b2b framing_error", 32'(framing_error), 32'h0);
    check("b2b parity_error", 32'(parity_error), 32'h0);
    check("b2b rx_busy", 32'(rx_busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side counterpart of the UART transmit path.
- Samples the serial line `Rx` on an externally supplied oversampling tick and detects the start bit.
- Recovers DATA_BITS data bits (LSB first), optionally checks parity, and checks the stop bit.
- Presents each received byte to the APB-side register block with a one-cycle valid strobe and sticky-until-next-frame error flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 16, baud_tick pulses per bit period (even, >= 4).
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected (used only with UART_RX_PARITY_EN).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
- Rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last received data word.
- rx_valid  output  1  one-clk pulse when a frame completes.
- framing_error  output  1  stop bit sampled low in the last frame.
- parity_error  output  1  parity mismatch in the last frame (0 without the macro).
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert by use):
  - rx_data=0, rx_valid=0, framing_error=0, parity_error=0, rx_busy=0.
  - State=IDLE, tick counter=0, bit counter=0, synchronizer flops=1, line_armed=1.
- Input path: 2-flop synchronizer on Rx (reset to 1). All decisions use the synchronized value `rxs`. This adds 2 clk latency.
- The tick counter (width clog2(OVERSAMPLE)) advances only on baud_tick. Clocks without baud_tick hold all state, except that rx_valid clears.
- IDLE:
  - If line_armed and baud_tick and rxs==0: go to START and clear the tick counter.
  - If rxs==1 on a baud_tick: set line_armed=1.
- START: on tick OVERSAMPLE/2-1 (mid start bit), sample rxs.
  - rxs==0: go to DATA, clear the tick counter and bit counter.
  - rxs==1 (glitch): return to IDLE. No flags change and rx_valid is not asserted.
- DATA: every OVERSAMPLE ticks (mid-bit), shift rxs into shift_reg MSB-side, giving LSB-first order.
  - After DATA_BITS samples, go to PARITY (macro defined) or STOP.
- PARITY (macro only): sample rxs after OVERSAMPLE ticks. Compute parity_bad = (^shift_reg ^ rxs ^ PARITY_ODD) != 0. Go to STOP.
- STOP: sample rxs after OVERSAMPLE ticks. In the same clk:
  - rx_data <= shift_reg.
  - framing_error <= ~rxs.
  - parity_error <= parity_bad.
  - rx_valid <= 1 on the next edge (one clk wide).
  - Go to IDLE.
  - If rxs==0, set line_armed=0, so a held-low line (break) does not retrigger until rxs returns high.
- rx_data and the error flags hold until the next completed frame. They are updated even on a framing error, and rx_valid still pulses.
- Frame end to rx_valid: 1 clk after the stop-bit mid-sample.
- rx_busy = (state != IDLE), combinational from the state register.
- Reset mid-frame: immediately returns to IDLE with reset values. The partial frame is discarded with no rx_valid.
- baud_tick stuck high is legal and makes the oversample rate equal to clk.
- An Rx edge inside a bit period is ignored; only mid-bit samples matter.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state exists, a frame is start + DATA_BITS + parity + stop, and parity_error is driven per the PARITY rule above.
- Undefined: the PARITY state is absent, a frame is start + DATA_BITS + stop, and parity_error is tied to 0.

Test Plan:
- Defaults, baud_tick every clk, send 0xA5 framed correctly (LSB first, stop=1) -> one rx_valid pulse; rx_data=0xA5; framing_error=0; parity_error=0; rx_busy low after.
- Send 0x3C with stop bit driven 0, then the line held low for 3 bit times, then high -> rx_valid pulses once; rx_data=0x3C; framing_error=1; no second frame until Rx returns high.
- Rx low pulse of 4 ticks while idle (shorter than half a bit) -> START aborts; no rx_valid; outputs unchanged.
- UART_RX_PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit 0 (wrong; even parity expects 1) -> rx_valid; rx_data=0x07; parity_error=1. Repeat with parity 1 -> parity_error=0.
- Assert rst during data bit 4 of a frame -> all outputs 0 immediately; no rx_valid. A following clean 0x55 frame is received correctly.
- Two back-to-back frames 0x01 and 0xFE with baud_tick every 3 clks -> two rx_valid pulses in order; rx_data=0x01 then 0xFE; no errors.
